// File: rtl/vz16_fetch_queue_if.sv
// Handshake bundle shared by the VZ16 fetch queue, instruction memory and decoder.
// The master modport is the fetch queue; the slave modport is its environment.
interface vz16_fetch_queue_if;
    logic        imem_req_valid;
    logic [15:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        dec_valid;
    logic [15:0] dec_inst;
    logic [15:0] dec_pc;
    logic        dec_ready;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output dec_valid,
        output dec_inst,
        output dec_pc,
        input  dec_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  dec_valid,
        input  dec_inst,
        input  dec_pc,
        output dec_ready
    );
endinterface

// File: rtl/vz16_fetch_queue.sv
// VZ16 instruction fetch front end: credit-limited sequential fetch into a PC-tagged
// FIFO feeding the decoder, with redirect flush and stale-response dropping.
module vz16_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic                clk,
    input logic                rst_n,
    vz16_fetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

    logic          rst_n_q;
    logic [15:0]   fetchPc_q, fetchPc_d;
    logic [15:0]   rspPc_q, rspPc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] dropCnt_q, dropCnt_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [15:0]   instMem_q [DEPTH];
    logic [15:0]   pcMem_q   [DEPTH];

    logic          reqFire;
    logic          popFire;
    logic          pushEn;
    logic [CW:0]   creditUsed;

    // Buffered plus in-flight instructions may never exceed the FIFO size.
    assign creditUsed         = {1'b0, count_q} + {1'b0, outstanding_q};
    assign bus.imem_req_valid = rst_n_q && !bus.redirect_valid && (creditUsed < CREDIT_LIMIT);
    assign bus.imem_req_addr  = fetchPc_q;
    assign bus.dec_valid      = (count_q != '0) && !bus.redirect_valid;
    assign bus.dec_inst       = instMem_q[rdPtr_q];
    assign bus.dec_pc         = pcMem_q[rdPtr_q];

    assign reqFire = bus.imem_req_valid && bus.imem_req_ready;
    assign popFire = bus.dec_valid && bus.dec_ready;

    always_comb begin
        fetchPc_d     = fetchPc_q;
        rspPc_d       = rspPc_q;
        count_d       = count_q;
        dropCnt_d     = dropCnt_q;
        wrPtr_d       = wrPtr_q;
        rdPtr_d       = rdPtr_q;
        pushEn        = 1'b0;
        outstanding_d = outstanding_q + CW'(reqFire) - CW'(bus.imem_rsp_valid);

        if (bus.redirect_valid) begin
            // Everything still in flight from earlier requests must be thrown away.
            fetchPc_d = bus.redirect_pc;
            rspPc_d   = bus.redirect_pc;
            count_d   = '0;
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            dropCnt_d = outstanding_q - CW'(bus.imem_rsp_valid);
        end else begin
            if (reqFire) begin
                fetchPc_d = fetchPc_q + 16'd1;
            end
            if (bus.imem_rsp_valid) begin
                if (dropCnt_q != '0) begin
                    dropCnt_d = dropCnt_q - CW'(1);
                end else begin
                    pushEn  = 1'b1;
                    rspPc_d = rspPc_q + 16'd1;
                end
            end
            if (pushEn) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (popFire) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            count_d = count_q + CW'(pushEn) - CW'(popFire);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_n_q       <= 1'b0;
            fetchPc_q     <= RESET_PC;
            rspPc_q       <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            dropCnt_q     <= '0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instMem_q[i] <= '0;
                pcMem_q[i]   <= '0;
            end
        end else begin
            rst_n_q       <= 1'b1;
            fetchPc_q     <= fetchPc_d;
            rspPc_q       <= rspPc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            dropCnt_q     <= dropCnt_d;
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            if (pushEn) begin
                instMem_q[wrPtr_q] <= bus.imem_rsp_data;
                pcMem_q[wrPtr_q]   <= rspPc_q;
            end
        end
    end
endmodule

// File: tb/tb_vz16_fetch_queue.sv
// Directed bench for vz16_fetch_queue with an in-order instruction memory model whose
// data is address XOR 16'hC000, so every expected word is easy to work out by hand.
module tb_vz16_fetch_queue;
    logic clk;
    logic rst_n;

    vz16_fetch_queue_if bus ();

    vz16_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          passedChecks = 0;
    int          failedChecks = 0;
    int          totalChecks  = 0;
    int          cycleNum     = 0;
    int          memLatency   = 1;
    int          reqCount     = 0;
    int          waitCycles   = 0;
    logic [15:0] pendAddr [$];
    int          pendDue  [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        totalChecks++;
        assert (observed === expected) passedChecks++;
        else begin
            failedChecks++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstN, input logic decReady, input logic memReady,
                                 input logic redirValid, input logic [15:0] redirPc);
        rst_n              = rstN;
        bus.dec_ready      = decReady;
        bus.imem_req_ready = memReady;
        bus.redirect_valid = redirValid;
        bus.redirect_pc    = redirPc;
        #1;
    endtask

    // Advance one clock: book-keep the memory handshakes seen before the edge, then drive
    // the response for the new cycle and let the DUT settle.
    task automatic stepCycle();
        logic        reqFire;
        logic        rspFire;
        logic        inReset;
        logic [15:0] reqAddr;
        reqFire = bus.imem_req_valid && bus.imem_req_ready;
        reqAddr = bus.imem_req_addr;
        rspFire = bus.imem_rsp_valid;
        inReset = !rst_n;
        @(posedge clk);
        cycleNum++;
        if (inReset) begin
            pendAddr.delete();
            pendDue.delete();
        end else begin
            if (rspFire && pendAddr.size() != 0) begin
                void'(pendAddr.pop_front());
                void'(pendDue.pop_front());
            end
            if (reqFire) begin
                pendAddr.push_back(reqAddr);
                pendDue.push_back(cycleNum + memLatency - 1);
                reqCount++;
            end
        end
        #1;
        if (pendAddr.size() != 0 && pendDue[0] <= cycleNum) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = pendAddr[0] ^ 16'hC000;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 16'h0000;
        end
        #1;
    endtask

    task automatic resetDut(input logic decReady);
        applyStimulus(1'b0, decReady, 1'b1, 1'b0, 16'h0000);
        stepCycle();
        stepCycle();
        checkOutput("rstReqValid", 16'(bus.imem_req_valid), 16'h0000);
        checkOutput("rstReqAddr", bus.imem_req_addr, 16'h0000);
        checkOutput("rstDecValid", 16'(bus.dec_valid), 16'h0000);
        checkOutput("rstDecInst", bus.dec_inst, 16'h0000);
        checkOutput("rstDecPc", bus.dec_pc, 16'h0000);
        applyStimulus(1'b1, decReady, 1'b1, 1'b0, 16'h0000);
        checkOutput("releaseCycleReqValid", 16'(bus.imem_req_valid), 16'h0000);
        stepCycle();
        checkOutput("firstReqValid", 16'(bus.imem_req_valid), 16'h0001);
        checkOutput("firstReqAddr", bus.imem_req_addr, 16'h0000);
        reqCount = 0;
    endtask

    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 16'h0000;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

        // Sequential fetch with single-cycle memory: first decoder output in the 4th cycle.
        memLatency = 1;
        resetDut(1'b1);
        stepCycle();
        checkOutput("seqNoBypass", 16'(bus.dec_valid), 16'h0000);
        stepCycle();
        for (int k = 0; k < 5; k++) begin
            checkOutput("seqDecValid", 16'(bus.dec_valid), 16'h0001);
            checkOutput("seqDecPc", bus.dec_pc, 16'(k));
            checkOutput("seqDecInst", bus.dec_inst, 16'(k) ^ 16'hC000);
            checkOutput("seqReqAddr", bus.imem_req_addr, 16'(k + 2));
            checkOutput("seqReqValid", 16'(bus.imem_req_valid), 16'h0001);
            stepCycle();
        end

        // Backpressure: exactly four requests fill the queue, then drain in order.
        resetDut(1'b0);
        for (int k = 0; k < 10; k++) stepCycle();
        checkOutput("fullReqCount", 16'(reqCount), 16'd4);
        checkOutput("fullReqValid", 16'(bus.imem_req_valid), 16'h0000);
        checkOutput("fullReqAddr", bus.imem_req_addr, 16'h0004);
        checkOutput("fullHeadPc", bus.dec_pc, 16'h0000);
        checkOutput("fullHeadInst", bus.dec_inst, 16'hC000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            checkOutput("drainValid", 16'(bus.dec_valid), 16'h0001);
            checkOutput("drainPc", bus.dec_pc, 16'(k));
            checkOutput("drainInst", bus.dec_inst, 16'(k) ^ 16'hC000);
            if (k == 1) begin
                checkOutput("resumeReqValid", 16'(bus.imem_req_valid), 16'h0001);
                checkOutput("resumeReqAddr", bus.imem_req_addr, 16'h0004);
            end
            stepCycle();
        end
        checkOutput("resumePc", bus.dec_pc, 16'h0004);
        checkOutput("resumeInst", bus.dec_inst, 16'hC004);

        // Redirect with three requests in flight; all three stale responses are dropped.
        memLatency = 4;
        resetDut(1'b1);
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("inflightReqAddr", bus.imem_req_addr, 16'h0003);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0100);
        checkOutput("redirReqValid", 16'(bus.imem_req_valid), 16'h0000);
        checkOutput("redirDecValid", 16'(bus.dec_valid), 16'h0000);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("redirNewReqValid", 16'(bus.imem_req_valid), 16'h0001);
        checkOutput("redirNewReqAddr", bus.imem_req_addr, 16'h0100);
        waitCycles = 0;
        while (bus.dec_valid !== 1'b1 && waitCycles < 20) begin
            stepCycle();
            waitCycles++;
        end
        checkOutput("redirWaitCycles", 16'(waitCycles), 16'd5);
        checkOutput("redirFirstPc", bus.dec_pc, 16'h0100);
        checkOutput("redirFirstInst", bus.dec_inst, 16'hC100);

        // Response and dequeue in the same cycle with two entries buffered.
        memLatency = 1;
        resetDut(1'b0);
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("simulHeadPc", bus.dec_pc, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        stepCycle();
        checkOutput("simulPc1", bus.dec_pc, 16'h0001);
        checkOutput("simulInst1", bus.dec_inst, 16'hC001);
        stepCycle();
        checkOutput("simulValid2", 16'(bus.dec_valid), 16'h0001);
        checkOutput("simulPc2", bus.dec_pc, 16'h0002);
        stepCycle();
        checkOutput("simulEmpty", 16'(bus.dec_valid), 16'h0000);

        // Response arriving in the redirect cycle is discarded, no later response is.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        stepCycle();
        checkOutput("rspRedirRspValid", 16'(bus.imem_rsp_valid), 16'h0001);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0200);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("rspRedirEmpty", 16'(bus.dec_valid), 16'h0000);
        checkOutput("rspRedirReqAddr", bus.imem_req_addr, 16'h0200);
        checkOutput("rspRedirReqValid", 16'(bus.imem_req_valid), 16'h0001);
        stepCycle();
        stepCycle();
        checkOutput("rspRedirNewValid", 16'(bus.dec_valid), 16'h0001);
        checkOutput("rspRedirNewPc", bus.dec_pc, 16'h0200);
        checkOutput("rspRedirNewInst", bus.dec_inst, 16'hC200);

        // Address wrap from FFFF back to 0000.
        resetDut(1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFE);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("wrapReqFFFE", bus.imem_req_addr, 16'hFFFE);
        stepCycle();
        checkOutput("wrapReqFFFF", bus.imem_req_addr, 16'hFFFF);
        stepCycle();
        checkOutput("wrapReq0000", bus.imem_req_addr, 16'h0000);
        checkOutput("wrapPcFFFE", bus.dec_pc, 16'hFFFE);
        checkOutput("wrapInstFFFE", bus.dec_inst, 16'h3FFE);
        stepCycle();
        checkOutput("wrapPcFFFF", bus.dec_pc, 16'hFFFF);
        checkOutput("wrapInstFFFF", bus.dec_inst, 16'h3FFF);
        stepCycle();
        checkOutput("wrapPc0000", bus.dec_pc, 16'h0000);
        checkOutput("wrapInst0000", bus.dec_inst, 16'hC000);

        // One-cycle reset in the middle of operation with three entries buffered.
        resetDut(1'b0);
        for (int k = 0; k < 4; k++) stepCycle();
        checkOutput("midHeadValid", 16'(bus.dec_valid), 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("midDecValid", 16'(bus.dec_valid), 16'h0000);
        checkOutput("midReqValid", 16'(bus.imem_req_valid), 16'h0000);
        checkOutput("midReqAddr", bus.imem_req_addr, 16'h0000);
        checkOutput("midDecPc", bus.dec_pc, 16'h0000);
        stepCycle();
        checkOutput("midRestartValid", 16'(bus.imem_req_valid), 16'h0001);
        checkOutput("midRestartAddr", bus.imem_req_addr, 16'h0000);
        stepCycle();
        stepCycle();
        checkOutput("midFirstValid", 16'(bus.dec_valid), 16'h0001);
        checkOutput("midFirstPc", bus.dec_pc, 16'h0000);
        checkOutput("midFirstInst", bus.dec_inst, 16'hC000);

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end
endmodule
